// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO serializer: FSM state encoding and default word width.
// The SIPO side and future deserializer framing use the same encodings.
package piso_serializer_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } piso_state_e;

    localparam int unsigned DefaultDataWidth = 4;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-word handshake and serial stream bundle for the PISO serializer.
interface piso_serializer_if #(
    parameter int unsigned DATA_WIDTH = piso_serializer_pkg::DefaultDataWidth
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  serial_out;
    logic                  serial_valid;
    logic                  serial_last;

    // Upstream producer / stream observer side
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  serial_out,
        input  serial_valid,
        input  serial_last
    );

    // Serializer side
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output serial_out,
        output serial_valid,
        output serial_last
    );

endinterface

// File: rtl/piso_shift_reg.sv
// Loadable shift register emitting one bit per shift, MSB-first or LSB-first.
// Vacated bit positions fill with zero; load takes priority over shift.
module piso_shift_reg #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  sbit
);

    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load) begin
            sreg_d = load_data;
        end else if (shift) begin
            if (MSB_FIRST) begin
                sreg_d = {sreg_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
                sreg_d = {1'b0, sreg_q[DATA_WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign sbit = MSB_FIRST ? sreg_q[DATA_WIDTH-1] : sreg_q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts a word on valid/ready and streams it one bit
// per clock, reloading on the last-bit edge so back-to-back words leave no gap.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input logic              clk,
    input logic              rst,
    piso_serializer_if.slave bus
);

    localparam int unsigned     CNT_W   = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH - 1);

    piso_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, shift, sbit;
    logic             ready, handshake, at_last;

    // Ready depends on registered state only, never on in_valid.
    assign at_last   = (state_q == StShift) && (cnt_q == '0);
    assign ready     = (state_q == StIdle) || at_last;
    assign handshake = bus.in_valid && ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (handshake) begin
                    load    = 1'b1;
                    cnt_d   = CNT_MAX;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q == '0) begin
                    if (handshake) begin
                        load  = 1'b1;
                        cnt_d = CNT_MAX;
                    end else begin
                        shift   = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    shift = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    piso_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_shift_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .load_data (bus.in_data),
        .sbit      (sbit)
    );

    assign bus.in_ready     = ready;
    assign bus.serial_valid = (state_q == StShift);
    assign bus.serial_out   = (state_q == StShift) && sbit;
    assign bus.serial_last  = at_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share one stimulus stream;
// accepted words are expanded into expected bits that a negedge monitor consumes.
module tb_piso_serializer;

    typedef struct {
        logic       b;
        logic       last;
        logic [3:0] word;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   left;
    exp_t q_m[$];
    exp_t q_l[$];

    piso_serializer_if #(.DATA_WIDTH(4)) bus_m ();
    piso_serializer_if #(.DATA_WIDTH(4)) bus_l ();

    piso_serializer #(.DATA_WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m.slave)
    );

    piso_serializer #(.DATA_WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from its own occupancy count.
    task automatic cycle(input logic v, input logic [3:0] d, input logic r, output logic acc);
        exp_t em, el;
        logic rdy;
        acc = 1'b0;
        rst = r;
        bus_m.in_valid = v;
        bus_l.in_valid = v;
        bus_m.in_data  = d;
        bus_l.in_data  = d;
        @(posedge clk);
        if (r) begin
            q_m.delete();
            q_l.delete();
            left = 0;
        end else begin
            rdy = (left <= 1);
            if (left > 0) left--;
            if (v && rdy) begin
                acc  = 1'b1;
                left = 4;
                for (int i = 0; i < 4; i++) begin
                    em.b = d[3-i];
                    el.b = d[i];
                    em.last = (i == 3);
                    el.last = (i == 3);
                    em.word = d;
                    el.word = d;
                    q_m.push_back(em);
                    q_l.push_back(el);
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, acc);
    endtask

    task automatic send_word(input logic [3:0] d);
        logic acc;
        acc = 1'b0;
        for (int n = 0; n < 16 && !acc; n++) cycle(1'b1, d, 1'b0, acc);
    endtask

    // Monitor: compares both serial streams and in_ready every cycle.
    initial begin : monitor
        exp_t       e;
        logic       exp_ready;
        logic [3:0] sipo_m;
        logic [3:0] sipo_l;
        sipo_m = '0;
        sipo_l = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_ready = (q_m.size() <= 1);
            chk("ready_msb", {3'b0, bus_m.in_ready}, {3'b0, exp_ready});
            chk("ready_lsb", {3'b0, bus_l.in_ready}, {3'b0, exp_ready});
            if (q_m.size() > 0) begin
                e = q_m.pop_front();
                chk("valid_msb", {3'b0, bus_m.serial_valid}, 4'd1);
                chk("bit_msb", {3'b0, bus_m.serial_out}, {3'b0, e.b});
                chk("last_msb", {3'b0, bus_m.serial_last}, {3'b0, e.last});
                if (e.last) chk("sipo_msb", {sipo_m[2:0], bus_m.serial_out}, e.word);
            end else begin
                chk("idle_msb", {1'b0, bus_m.serial_valid, bus_m.serial_out,
                                 bus_m.serial_last}, 4'd0);
            end
            if (q_l.size() > 0) begin
                e = q_l.pop_front();
                chk("valid_lsb", {3'b0, bus_l.serial_valid}, 4'd1);
                chk("bit_lsb", {3'b0, bus_l.serial_out}, {3'b0, e.b});
                chk("last_lsb", {3'b0, bus_l.serial_last}, {3'b0, e.last});
                if (e.last) chk("sipo_lsb", {bus_l.serial_out, sipo_l[3:1]}, e.word);
            end else begin
                chk("idle_lsb", {1'b0, bus_l.serial_valid, bus_l.serial_out,
                                 bus_l.serial_last}, 4'd0);
            end
            if (bus_m.serial_valid) sipo_m = {sipo_m[2:0], bus_m.serial_out};
            if (bus_l.serial_valid) sipo_l = {bus_l.serial_out, sipo_l[3:1]};
        end
    end

    initial begin : stimulus
        logic acc;
        errors = 0;
        checks = 0;
        left   = 0;
        // Reset for two edges, then hold idle
        cycle(1'b0, 4'h0, 1'b1, acc);
        cycle(1'b0, 4'h0, 1'b1, acc);
        idle(4);
        // Single word, both bit orders
        send_word(4'b1011);
        idle(6);
        // Back-to-back words with valid held
        send_word(4'b1010);
        send_word(4'b0110);
        idle(6);
        // Word offered mid-stream is held off until the last-bit edge
        send_word(4'b1000);
        send_word(4'hF);
        idle(6);
        // Reset during bit 2, then a clean word
        send_word(4'b1100);
        idle(1);
        cycle(1'b0, 4'h0, 1'b1, acc);
        idle(2);
        send_word(4'b0001);
        idle(6);
        // Randomized valid/data with occasional resets
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 59) == 0), acc);
        end
        idle(8);
        chk("drain_msb", 4'(q_m.size()), 4'd0);
        chk("drain_lsb", 4'(q_l.size()), 4'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
